// File: rtl/etage_di_pkg.sv
// Shared processor definitions: data/register widths, opcode encoding and
// the per-opcode operand usage decode used by the decode/issue stage.
package etage_di_pkg;

    localparam int DATA_W = 8;
    localparam int NREG_W = 4;
    localparam int DEPTH  = 3;

    typedef enum logic [7:0] {
        OP_NOP   = 8'h00,
        OP_ADD   = 8'h01,
        OP_MUL   = 8'h02,
        OP_SOU   = 8'h03,
        OP_DIV   = 8'h04,
        OP_COP   = 8'h05,
        OP_AFC   = 8'h06,
        OP_LOAD  = 8'h07,
        OP_STORE = 8'h08
    } opcode_e;

    typedef struct packed {
        logic known;
        logic use_b;
        logic use_c;
        logic writer;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t info;
        info = '0;
        case (op)
            OP_NOP:                        info.known = 1'b1;
            OP_ADD, OP_MUL, OP_SOU, OP_DIV: info = '{known: 1'b1, use_b: 1'b1, use_c: 1'b1, writer: 1'b1};
            OP_COP:                        info = '{known: 1'b1, use_b: 1'b1, use_c: 1'b0, writer: 1'b1};
            OP_AFC, OP_LOAD:               info = '{known: 1'b1, use_b: 1'b0, use_c: 1'b0, writer: 1'b1};
            OP_STORE:                      info = '{known: 1'b1, use_b: 1'b1, use_c: 1'b0, writer: 1'b0};
            default:                       info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/etage_di_if.sv
// LI/DI decode-stage bus: instruction in, register-bank read port, stall
// back-pressure and the registered DI/EX outputs.
interface etage_di_if #(
    parameter int DATA_W = 8,
    parameter int NREG_W = 4
);
    logic [DATA_W-1:0] LI_OP, LI_A, LI_B, LI_C;
    logic              LI_VALID;
    logic              STALL;
    logic [NREG_W-1:0] RB_ADDR_A, RB_ADDR_B;
    logic [DATA_W-1:0] RB_QA, RB_QB;
    logic [DATA_W-1:0] DI_OP, DI_A, DI_B, DI_C;

    modport master (
        output LI_OP, LI_A, LI_B, LI_C, LI_VALID, RB_QA, RB_QB,
        input  STALL, RB_ADDR_A, RB_ADDR_B, DI_OP, DI_A, DI_B, DI_C
    );

    modport slave (
        input  LI_OP, LI_A, LI_B, LI_C, LI_VALID, RB_QA, RB_QB,
        output STALL, RB_ADDR_A, RB_ADDR_B, DI_OP, DI_A, DI_B, DI_C
    );
endinterface

// File: rtl/etage_di_scoreboard.sv
// In-flight destination tracker: a shift register of {valid, dst} slots
// (EX, MEM, RE) compared against the current instruction's sources.
module scoreboard_di #(
    parameter int NREG_W = 4,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chk_b_en,
    input  logic [NREG_W-1:0] chk_b,
    input  logic              chk_c_en,
    input  logic [NREG_W-1:0] chk_c,
    input  logic              push_valid,
    input  logic [NREG_W-1:0] push_dst,
    output logic              hazard
);
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [NREG_W-1:0] dst_q [DEPTH];
    logic [NREG_W-1:0] dst_d [DEPTH];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = push_valid;
        dst_d[0] = push_dst;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dst_d[i] = dst_q[i-1];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && ((chk_b_en && chk_b == dst_q[i]) ||
                             (chk_c_en && chk_c == dst_q[i])))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dst_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) dst_q[i] <= dst_d[i];
        end
    end

endmodule

// File: rtl/etage_di.sv
// Decode/issue stage: reads operands from the register bank, stalls on RAW
// hazards against in-flight writers and registers the DI/EX operands.
module etage_di #(
    parameter int DATA_W = etage_di_pkg::DATA_W,
    parameter int NREG_W = etage_di_pkg::NREG_W,
    parameter int DEPTH  = etage_di_pkg::DEPTH
) (
    input logic       CLK,
    input logic       RST,
    etage_di_if.slave bus
);
    import etage_di_pkg::*;

    op_info_t          info;
    logic              use_b, use_c, hazard, issue;
    logic [DATA_W-1:0] di_op_q, di_op_d, di_a_q, di_a_d;
    logic [DATA_W-1:0] di_b_q, di_b_d, di_c_q, di_c_d;

    // Opcodes with any bit set above the 8-bit encoding are unknown as well.
    always_comb begin
        info = decode_op(bus.LI_OP[7:0]);
        if ((bus.LI_OP >> 8) != '0) info = '0;
    end

    assign use_b = bus.LI_VALID & info.use_b;
    assign use_c = bus.LI_VALID & info.use_c;
    assign issue = bus.LI_VALID & info.known & ~hazard;

    assign bus.RB_ADDR_A = bus.LI_B[NREG_W-1:0];
    assign bus.RB_ADDR_B = bus.LI_C[NREG_W-1:0];
    assign bus.STALL     = hazard;

    scoreboard_di #(.NREG_W(NREG_W), .DEPTH(DEPTH)) u_scoreboard (
        .clk        (CLK),
        .rst        (RST),
        .chk_b_en   (use_b),
        .chk_b      (bus.LI_B[NREG_W-1:0]),
        .chk_c_en   (use_c),
        .chk_c      (bus.LI_C[NREG_W-1:0]),
        .push_valid (issue & info.writer),
        .push_dst   (bus.LI_A[NREG_W-1:0]),
        .hazard     (hazard)
    );

    always_comb begin
        di_op_d = '0;
        di_a_d  = '0;
        di_b_d  = '0;
        di_c_d  = '0;
        if (issue) begin
            di_op_d = bus.LI_OP;
            di_a_d  = bus.LI_A;
            di_b_d  = info.use_b ? bus.RB_QA : bus.LI_B;
            di_c_d  = info.use_c ? bus.RB_QB : bus.LI_C;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            di_op_q <= '0;
            di_a_q  <= '0;
            di_b_q  <= '0;
            di_c_q  <= '0;
        end else begin
            di_op_q <= di_op_d;
            di_a_q  <= di_a_d;
            di_b_q  <= di_b_d;
            di_c_q  <= di_c_d;
        end
    end

    assign bus.DI_OP = di_op_q;
    assign bus.DI_A  = di_a_q;
    assign bus.DI_B  = di_b_q;
    assign bus.DI_C  = di_c_q;

endmodule

// File: tb/tb_etage_di.sv
// Bench for etage_di: directed hazard/reset scenarios plus random instruction
// streams, checked by a queue-based scoreboard against a timing-level model.
module tb_etage_di;
    localparam int DW    = 8;
    localparam int NW    = 4;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    etage_di_if #(.DATA_W(DW), .NREG_W(NW)) bus();

    etage_di #(.DATA_W(DW), .NREG_W(NW), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Register bank contents are a fixed function of the index.
    function automatic logic [7:0] rb_val(input logic [3:0] i);
        return ({4'h0, i} * 8'd17) ^ 8'h5A;
    endfunction

    assign bus.RB_QA = rb_val(bus.RB_ADDR_A);
    assign bus.RB_QB = rb_val(bus.RB_ADDR_B);

    typedef struct {
        int         edge_n;
        logic [7:0] op, a, b, c;
    } exp_t;

    typedef struct {
        int         edge_n;
        logic [3:0] dst;
    } wr_t;

    exp_t expq[$];
    wr_t  hist[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: compares the registered DI outputs after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            #4;
            while (expq.size() > 0 && expq[0].edge_n <= edge_cnt) begin
                exp_t e;
                e = expq.pop_front();
                chk("di_out", {bus.DI_OP, bus.DI_A, bus.DI_B, bus.DI_C},
                    {e.op, e.a, e.b, e.c});
            end
        end
    end

    // One clock of stimulus: inputs already driven; check stall and read
    // addresses, predict the DI outputs for the coming edge, then advance.
    task automatic cycle(input logic r, output logic accepted);
        int         target;
        logic       haz, known, rd_b, rd_c, wr;
        logic [7:0] op;
        exp_t       e;
        #1;
        target = edge_cnt + 1;
        op     = bus.LI_OP;
        known  = (op <= 8'd8);
        rd_b   = op inside {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd8};
        rd_c   = op inside {8'd1, 8'd2, 8'd3, 8'd4};
        wr     = known && op != 8'd0 && op != 8'd8;
        haz    = 1'b0;
        if (bus.LI_VALID) begin
            foreach (hist[i]) begin
                if (target - hist[i].edge_n <= DEPTH &&
                    ((rd_b && hist[i].dst == bus.LI_B[3:0]) ||
                     (rd_c && hist[i].dst == bus.LI_C[3:0])))
                    haz = 1'b1;
            end
        end
        chk("stall", {31'd0, bus.STALL}, {31'd0, haz});
        chk("rb_addr", {24'd0, bus.RB_ADDR_A, bus.RB_ADDR_B},
            {24'd0, bus.LI_B[3:0], bus.LI_C[3:0]});

        e = '{edge_n: target, op: 8'h00, a: 8'h00, b: 8'h00, c: 8'h00};
        if (r) begin
            hist.delete();
        end else if (bus.LI_VALID && !haz && known) begin
            e.op = op;
            e.a  = bus.LI_A;
            e.b  = rd_b ? rb_val(bus.LI_B[3:0]) : bus.LI_B;
            e.c  = rd_c ? rb_val(bus.LI_C[3:0]) : bus.LI_C;
            if (wr) hist.push_back('{edge_n: target, dst: bus.LI_A[3:0]});
        end
        while (hist.size() > 0 && target - hist[0].edge_n >= DEPTH) void'(hist.pop_front());
        expq.push_back(e);
        accepted = r ? 1'b0 : !haz;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, a, b, c, input logic v);
        bus.LI_OP    = op;
        bus.LI_A     = a;
        bus.LI_B     = b;
        bus.LI_C     = c;
        bus.LI_VALID = v;
    endtask

    // Hold an instruction in LI until accepted; returns the stall count.
    task automatic issue(input logic [7:0] op, a, b, c, output int waits);
        logic acc;
        drive(op, a, b, c, 1'b1);
        rst   = 1'b0;
        waits = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, acc);
            if (acc) break;
            waits++;
        end
        if (waits >= 10) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got %0d stalls expected at most %0d", waits, DEPTH);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < n; k++) cycle(1'b0, acc);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        rst = 1'b1;
        for (int k = 0; k < n; k++) cycle(1'b1, acc);
        rst = 1'b0;
    endtask

    initial begin
        int w;
        logic acc;
        rst = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with an ADD sitting in LI.
        drive(8'h01, 8'h03, 8'h01, 8'h02, 1'b1);
        do_reset(2);

        // Independent AFCs.
        issue(8'h06, 8'h01, 8'h05, 8'h00, w);
        chk("afc1_waits", w, 0);
        issue(8'h06, 8'h02, 8'h07, 8'h00, w);
        chk("afc2_waits", w, 0);
        idle(3);

        // RAW on R1: three bubbles, then ADD with bank operands.
        issue(8'h06, 8'h01, 8'h05, 8'h00, w);
        issue(8'h01, 8'h03, 8'h01, 8'h02, w);
        chk("raw_waits", w, DEPTH);
        idle(3);

        // COP reading R1 right after an unrelated AFC.
        issue(8'h06, 8'h02, 8'h09, 8'h00, w);
        issue(8'h05, 8'h04, 8'h01, 8'h00, w);
        chk("cop_waits", w, 0);
        idle(3);

        // Unknown opcode writing nothing, then a dependent ADD.
        issue(8'hFF, 8'h01, 8'h02, 8'h03, w);
        chk("unk_waits", w, 0);
        issue(8'h01, 8'h03, 8'h01, 8'h01, w);
        chk("after_unk_waits", w, 0);
        idle(3);

        // Source equal to own destination.
        issue(8'h01, 8'h01, 8'h01, 8'h02, w);
        chk("self_dep_waits", w, 0);
        idle(3);

        // Reset while stalled, then the held instruction issues at once.
        issue(8'h06, 8'h05, 8'h11, 8'h00, w);
        drive(8'h01, 8'h06, 8'h05, 8'h05, 1'b1);
        cycle(1'b0, acc);
        chk("stalled_before_rst", {31'd0, acc}, 32'd0);
        do_reset(1);
        issue(8'h01, 8'h06, 8'h05, 8'h05, w);
        chk("post_rst_waits", w, 0);

        // Random stream biased towards low register indices.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] op, a, b, c;
            int         r;
            r  = $urandom_range(0, 11);
            op = (r <= 8) ? 8'(r) : ((r == 9) ? 8'hFF : 8'(8'h09 + $urandom_range(0, 100)));
            a  = {4'($urandom), 4'($urandom_range(0, 3))};
            b  = {4'($urandom), 4'($urandom_range(0, 3))};
            c  = {4'($urandom), 4'($urandom_range(0, 3))};
            if ($urandom_range(0, 99) < 15) idle(1);
            if ($urandom_range(0, 199) == 0) do_reset(1);
            issue(op, a, b, c, w);
        end
        idle(2);
        #5;
        chk("drain", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule
